// File: rtl/alsu_seg_display.sv
// Display stage for the ALSU: shows the 6-bit result in decimal on a 4-digit
// common-anode multiplexed 7-segment display, or a blinking "Err-" while alarmed.
module alsu_seg_display #(
    parameter int REFRESH_DIV = 4,
    parameter int BLINK_DIV   = 2,
    parameter int ERR_HOLD    = 3
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [5:0]  out_in,
    input  logic [15:0] leds_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        err_flag
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HW = $clog2(ERR_HOLD + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {ST_SHOW, ST_ERR, ST_HOLD} state_t;

    logic [5:0]    r_res_q;
    logic [15:0]   r_leds_q;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [HW-1:0] r_hold_cnt;
    state_t        r_state;

    state_t        w_state_nxt;
    logic          w_presc_wrap;
    logic          w_frame_tick;
    logic          w_leds_any;
    logic [2:0]    w_tens;
    logic [3:0]    w_ones;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;

    function automatic logic [6:0] f_dec7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign w_presc_wrap = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_frame_tick = w_presc_wrap && (r_idx == 2'd3);
    assign w_leds_any   = |r_leds_q;
    assign w_tens       = 3'(r_res_q / 6'd10);
    assign w_ones       = 4'(r_res_q % 6'd10);
    assign err_flag     = (r_state != ST_SHOW);

    // NOTE: every state element uses non-blocking assignment so all flops sample
    // the same pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_res_q  <= '0;
            r_leds_q <= '0;
            r_presc  <= '0;
            r_idx    <= '0;
        end else begin
            r_res_q  <= out_in;
            r_leds_q <= leds_in;
            r_presc  <= w_presc_wrap ? '0 : r_presc + PW'(1);
            if (w_presc_wrap)
                r_idx <= r_idx + 2'd1;
        end
    end

    // NOTE: outputs of a combinational block get a default first, so no path
    // through the case leaves them unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_SHOW: if (w_leds_any) w_state_nxt = ST_ERR;
            ST_ERR:  if (!w_leds_any) w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (w_leds_any)
                    w_state_nxt = ST_ERR;
                else if (w_frame_tick && (r_hold_cnt <= HW'(1)))
                    w_state_nxt = ST_SHOW;
            end
            default: w_state_nxt = ST_SHOW;
        endcase
    end

    // Blink state is forced clear in SHOW, so entering ERR always starts visible.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state       <= ST_SHOW;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_hold_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_SHOW) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
            end else if (w_frame_tick) begin
                if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
            if (r_state == ST_ERR && !w_leds_any)
                r_hold_cnt <= HW'(ERR_HOLD);
            else if (r_state == ST_HOLD && !w_leds_any && w_frame_tick)
                r_hold_cnt <= r_hold_cnt - HW'(1);
        end
    end

    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        if (r_state == ST_SHOW) begin
            w_an_nxt = ~(4'b0001 << r_idx);
            case (r_idx)
                2'd0:    w_seg_nxt = f_dec7(w_ones);
                2'd1:    w_seg_nxt = (w_tens == 3'd0) ? SEG_BLANK : f_dec7({1'b0, w_tens});
                default: w_seg_nxt = SEG_BLANK;
            endcase
        end else if (!r_blink_phase) begin
            w_an_nxt = ~(4'b0001 << r_idx);
            case (r_idx)
                2'd0:    w_seg_nxt = SEG_DASH;
                2'd1:    w_seg_nxt = SEG_R;
                2'd2:    w_seg_nxt = SEG_R;
                default: w_seg_nxt = SEG_E;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= w_an_nxt;
            seg <= w_seg_nxt;
        end
    end

endmodule

// File: tb/tb_alsu_seg_display.sv
// Directed bench for alsu_seg_display with default parameters
// (REFRESH_DIV=4, BLINK_DIV=2, ERR_HOLD=3).
module tb_alsu_seg_display;

    logic        CLK;
    logic        RST_n;
    logic [5:0]  out_in;
    logic [15:0] leds_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        err_flag;

    int n_vec  = 0;
    int n_miss = 0;

    logic [6:0] cap_seg [4];
    logic [3:0] cap_seen;

    alsu_seg_display #(
        .REFRESH_DIV(4),
        .BLINK_DIV  (2),
        .ERR_HOLD   (3)
    ) dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .out_in  (out_in),
        .leds_in (leds_in),
        .an      (an),
        .seg     (seg),
        .err_flag(err_flag)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Records the segment pattern shown on each selected digit over a window.
    task automatic capture(input int cycles);
        cap_seen = 4'b0000;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            case (an)
                4'b1110: begin cap_seg[0] = seg; cap_seen[0] = 1'b1; end
                4'b1101: begin cap_seg[1] = seg; cap_seen[1] = 1'b1; end
                4'b1011: begin cap_seg[2] = seg; cap_seen[2] = 1'b1; end
                4'b0111: begin cap_seg[3] = seg; cap_seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic wait_an(input string tag, input logic [3:0] val, input int budget);
        int i;
        i = 0;
        @(negedge CLK);
        while (an !== val && i < budget) begin
            @(negedge CLK);
            i++;
        end
        check(tag, 16'(an), 16'(val));
    endtask

    initial begin
        logic [3:0] exp_an;
        int first_zero;
        int blank_run;
        int drops;

        RST_n   = 1'b1;
        out_in  = 6'd0;
        leds_in = 16'h0000;

        // 1. async reset values, then scan order and dwell after release
        #2 RST_n = 1'b0;
        #1;
        check("rst_an", 16'(an), 16'h000F);
        check("rst_seg", 16'(seg), 16'h007F);
        check("rst_err", 16'(err_flag), 16'h0000);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge CLK);
            #1;
            exp_an = ~(4'b0001 << (((n - 1) / 4) % 4));
            check($sformatf("scan_an_e%0d", n), 16'(an), 16'(exp_an));
        end

        // 2. 47 -> tens 4, ones 7, upper digits blank
        @(negedge CLK);
        out_in = 6'd47;
        repeat (20) @(negedge CLK);
        capture(16);
        check("d47_seen", 16'(cap_seen), 16'h000F);
        check("d47_dig0", 16'(cap_seg[0]), 16'(7'b1111000));
        check("d47_dig1", 16'(cap_seg[1]), 16'(7'b0011001));
        check("d47_dig2", 16'(cap_seg[2]), 16'(7'b1111111));
        check("d47_dig3", 16'(cap_seg[3]), 16'(7'b1111111));

        // 3. single digit with leading-zero suppression, then zero
        out_in = 6'd5;
        repeat (20) @(negedge CLK);
        capture(16);
        check("d5_dig0", 16'(cap_seg[0]), 16'(7'b0010010));
        check("d5_dig1", 16'(cap_seg[1]), 16'(7'b1111111));
        out_in = 6'd0;
        repeat (20) @(negedge CLK);
        capture(16);
        check("d0_dig0", 16'(cap_seg[0]), 16'(7'b1000000));
        check("d0_dig1", 16'(cap_seg[1]), 16'(7'b1111111));

        // 4. alarm: two-edge flag latency, Err- content, blink timing
        @(negedge CLK);
        leds_in = 16'hFFFF;
        @(posedge CLK);
        #1 check("err_lat_e1", 16'(err_flag), 16'h0000);
        @(posedge CLK);
        #1 check("err_lat_e2", 16'(err_flag), 16'h0001);
        @(posedge CLK);
        capture(16);
        check("err_seen", 16'(cap_seen), 16'h000F);
        check("err_dig0", 16'(cap_seg[0]), 16'(7'b0111111));
        check("err_dig1", 16'(cap_seg[1]), 16'(7'b0101111));
        check("err_dig2", 16'(cap_seg[2]), 16'(7'b0101111));
        check("err_dig3", 16'(cap_seg[3]), 16'(7'b0000110));
        wait_an("blink_off_start", 4'b1111, 40);
        check("blink_off_seg", 16'(seg), 16'h007F);
        blank_run = 0;
        while (an === 4'b1111 && blank_run < 100) begin
            blank_run++;
            @(negedge CLK);
        end
        check("blink_off_len", 16'(blank_run), 16'd32);
        check("blink_on_again", 16'(an !== 4'b1111), 16'h0001);

        // 5. alarm clears with 63 pending: flag holds for exactly three frames
        leds_in = 16'h0000;
        out_in  = 6'd63;
        first_zero = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge CLK);
            #1;
            if (first_zero == 0 && err_flag === 1'b0)
                first_zero = n;
        end
        check("hold_drop_not_early", 16'(first_zero >= 35), 16'h0001);
        check("hold_drop_not_late", 16'(first_zero <= 50 && first_zero != 0), 16'h0001);
        repeat (4) @(negedge CLK);
        capture(16);
        check("d63_dig0", 16'(cap_seg[0]), 16'(7'b0110000));
        check("d63_dig1", 16'(cap_seg[1]), 16'(7'b0000010));
        check("d63_dig3", 16'(cap_seg[3]), 16'(7'b1111111));

        // re-assert during HOLD: flag must never drop
        @(negedge CLK);
        leds_in = 16'h0001;
        repeat (3) @(posedge CLK);
        #1 check("reassert_err_on", 16'(err_flag), 16'h0001);
        @(negedge CLK);
        leds_in = 16'h0000;
        drops = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (err_flag !== 1'b1) drops++;
        end
        leds_in = 16'h8000;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (err_flag !== 1'b1) drops++;
        end
        check("reassert_no_drop", 16'(drops), 16'h0000);

        // 6. asynchronous reset while showing the error digits
        wait_an("pre_rst_dig0", 4'b1110, 80);
        check("pre_rst_dash", 16'(seg), 16'(7'b0111111));
        #1 RST_n = 1'b0;
        #1;
        check("async_rst_an", 16'(an), 16'h000F);
        check("async_rst_seg", 16'(seg), 16'h007F);
        check("async_rst_err", 16'(err_flag), 16'h0000);
        leds_in = 16'h0000;
        out_in  = 6'd0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        check("rerun_an", 16'(an), 16'h000E);
        check("rerun_err", 16'(err_flag), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
